// File: rtl/binary_maxpool_stage.sv
// 2x2 stride-2 max-pooling (bitwise OR) over a binary feature map.
// Streams rows from the feature-map SRAM and writes pooled rows out.
module binary_maxpool_stage (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        pool_run,
    input  logic [1:0]  pool_dim,
    output logic        pool_busy,
    output logic        pool_done,
    output logic [11:0] pool_sram_read_address,
    input  logic [15:0] sram_pool_read_data,
    output logic [11:0] pool_sram_write_address,
    output logic [15:0] pool_sram_write_data,
    output logic        pool_sram_write_enable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  m_q, m_d;
    logic [11:0] raddr_q, raddr_d;
    logic        rvalid_q, rvalid_d;
    logic [3:0]  ridx_q, ridx_d;
    logic [15:0] hold_q, hold_d;
    logic        we_q, we_d;
    logic [11:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        start;
    logic        last_rd;
    logic        last_wr;
    logic        wr_now;
    logic [3:0]  m_dec;
    logic [3:0]  half_m;
    logic [15:0] mask;
    logic [15:0] masked;
    logic [15:0] pooled;

    always_comb begin
        m_dec = 4'd8;
        unique case (1'b1)
            pool_dim[1]:                 m_dec = 4'd14;
            !pool_dim[1] &&  pool_dim[0]: m_dec = 4'd10;
            !pool_dim[1] && !pool_dim[0]: m_dec = 4'd8;
        endcase
    end

    assign half_m  = {1'b0, m_q[3:1]};
    assign start   = (state_q == IDLE) && pool_run;
    assign last_rd = (state_q == READ) &&
                     (raddr_q == {8'h00, m_q - 4'd1});
    assign last_wr = (state_q == DRAIN) && we_q &&
                     (waddr_q == {8'h00, half_m - 4'd1});
    assign wr_now  = rvalid_q && ridx_q[0];

    // Columns at or beyond M carry stale data and must not leak into the OR.
    always_comb begin
        mask = '0;
        for (int i = 0; i < 16; i++) begin
            mask[i] = (i < int'(m_q));
        end
    end

    assign masked = sram_pool_read_data & mask;

    always_comb begin
        pooled = '0;
        for (int j = 0; j < 8; j++) begin
            pooled[j] = hold_q[2*j] | hold_q[2*j+1] |
                        masked[2*j] | masked[2*j+1];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pool_run) state_d = READ;
            READ:    if (last_rd)  state_d = DRAIN;
            DRAIN:   if (last_wr)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_d      = m_q;
        raddr_d  = '0;
        rvalid_d = (state_q == READ);
        ridx_d   = raddr_q[3:0];
        hold_d   = hold_q;
        we_d     = wr_now;
        waddr_d  = '0;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        done_d   = last_wr;

        if (start) begin
            m_d    = m_dec;
            busy_d = 1'b1;
        end
        if (last_wr) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            READ:    raddr_d = last_rd ? raddr_q : raddr_q + 12'd1;
            DRAIN:   raddr_d = last_wr ? 12'd0 : raddr_q;
            default: raddr_d = '0;
        endcase

        if (rvalid_q && !ridx_q[0]) begin
            hold_d = masked;
        end
        if (wr_now) begin
            waddr_d = {9'd0, ridx_q[3:1]};
            wdata_d = pooled;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= IDLE;
            m_q      <= '0;
            raddr_q  <= '0;
            rvalid_q <= 1'b0;
            ridx_q   <= '0;
            hold_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            raddr_q  <= raddr_d;
            rvalid_q <= rvalid_d;
            ridx_q   <= ridx_d;
            hold_q   <= hold_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign pool_busy               = busy_q;
    assign pool_done               = done_q;
    assign pool_sram_read_address  = raddr_q;
    assign pool_sram_write_address = waddr_q;
    assign pool_sram_write_data    = wdata_q;
    assign pool_sram_write_enable  = we_q;

endmodule

// File: tb/tb_binary_maxpool_stage.sv
// Directed bench for binary_maxpool_stage with a registered-read SRAM model.
// Checks cycle-exact busy/done, read addresses and every pooled write.
module tb_binary_maxpool_stage;

    logic        clk;
    logic        reset_b;
    logic        pool_run;
    logic [1:0]  pool_dim;
    logic        pool_busy;
    logic        pool_done;
    logic [11:0] rd_addr;
    logic [15:0] rd_data;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;

    logic [15:0] mem [16];
    logic [15:0] e    [7];

    int checks   = 0;
    int failures = 0;

    binary_maxpool_stage dut (
        .clk                     (clk),
        .reset_b                 (reset_b),
        .pool_run                (pool_run),
        .pool_dim                (pool_dim),
        .pool_busy               (pool_busy),
        .pool_done               (pool_done),
        .pool_sram_read_address  (rd_addr),
        .sram_pool_read_data     (rd_data),
        .pool_sram_write_address (wr_addr),
        .pool_sram_write_data    (wr_data),
        .pool_sram_write_enable  (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr[3:0]];

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {15'd0, pool_busy}, 16'd0);
        chk({tag, "_done"}, {15'd0, pool_done}, 16'd0);
        chk({tag, "_we"},   {15'd0, wr_en},     16'd0);
        chk({tag, "_ra"},   {4'd0, rd_addr},    16'd0);
        chk({tag, "_wa"},   {4'd0, wr_addr},    16'd0);
    endtask

    task automatic fill(input logic [15:0] ev, input logic [15:0] od);
        for (int i = 0; i < 16; i++) mem[i] = i[0] ? od : ev;
    endtask

    task automatic run_check(input logic [1:0] dim, input int m,
                             input bit started, input bit repulse,
                             input bit chain);
        if (!started) begin
            @(negedge clk);
            pool_run = 1'b1;
            pool_dim = dim;
        end
        @(posedge clk);
        #1 pool_run = 1'b0;
        for (int n = 1; n <= m + 3; n++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", n), {15'd0, pool_busy},
                {15'd0, (n <= m + 2)});
            chk($sformatf("done_c%0d", n), {15'd0, pool_done},
                {15'd0, (n == m + 3)});
            if (n <= m)
                chk($sformatf("ra_c%0d", n), {4'd0, rd_addr}, 16'(n - 1));
            chk($sformatf("we_c%0d", n), {15'd0, wr_en},
                {15'd0, (n >= 4 && n <= m + 2 && n % 2 == 0)});
            if (n >= 4 && n <= m + 2 && n % 2 == 0) begin
                chk($sformatf("wa_c%0d", n), {4'd0, wr_addr},
                    16'((n - 4) / 2));
                chk($sformatf("wd_c%0d", n), wr_data, e[(n - 4) / 2]);
            end
            if (repulse && n == 3) begin
                pool_run = 1'b1;
                pool_dim = 2'b10;
            end
            if (repulse && n == 4) pool_run = 1'b0;
            if (chain && n == m + 3) pool_run = 1'b1;
        end
        if (!chain) begin
            @(negedge clk);
            chk_idle("post");
            chk("post_wd_hold", wr_data, e[m / 2 - 1]);
        end
    endtask

    initial begin
        reset_b  = 1'b0;
        pool_run = 1'b0;
        pool_dim = 2'b00;
        fill(16'h0000, 16'h0000);
        #12;
        chk_idle("rst");
        chk("rst_wd", wr_data, 16'h0000);
        @(negedge clk);
        reset_b = 1'b1;

        fill(16'h00FF, 16'h00FF);
        for (int k = 0; k < 7; k++) e[k] = 16'h000F;
        run_check(2'b00, 8, 1'b0, 1'b0, 1'b0);

        fill(16'h5555, 16'hAAAA);
        for (int k = 0; k < 7; k++) e[k] = 16'h007F;
        run_check(2'b10, 14, 1'b0, 1'b0, 1'b0);

        fill(16'h0000, 16'h0000);
        mem[3] = 16'h0200;
        for (int k = 0; k < 7; k++) e[k] = 16'h0000;
        e[1] = 16'h0010;
        run_check(2'b01, 10, 1'b0, 1'b0, 1'b0);

        fill(16'hFC00, 16'hFC00);
        for (int k = 0; k < 7; k++) e[k] = 16'h0000;
        run_check(2'b01, 10, 1'b0, 1'b0, 1'b0);

        fill(16'h00FF, 16'h00FF);
        for (int k = 0; k < 7; k++) e[k] = 16'h000F;
        pool_dim = 2'b00;
        run_check(2'b00, 8, 1'b0, 1'b1, 1'b1);
        pool_dim = 2'b00;
        run_check(2'b00, 8, 1'b1, 1'b0, 1'b0);

        fill(16'h5555, 16'hAAAA);
        @(negedge clk);
        pool_run = 1'b1;
        pool_dim = 2'b10;
        @(posedge clk);
        #1 pool_run = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("ar_busy", {15'd0, pool_busy}, 16'd1);
        reset_b = 1'b0;
        #1;
        chk_idle("ar");
        chk("ar_wd", wr_data, 16'h0000);
        repeat (2) @(negedge clk);
        chk_idle("ar_hold");
        reset_b = 1'b1;
        @(negedge clk);
        chk_idle("ar_rel");

        fill(16'h00FF, 16'h00FF);
        for (int k = 0; k < 7; k++) e[k] = 16'h000F;
        run_check(2'b00, 8, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/binary_maxpool_stage.md
# binary_maxpool_stage

Downstream stage of the binary convolution engine. It reads the binary feature map that the convolution wrote into the output SRAM, one 16-bit row per word. It applies 2x2 stride-2 max-pooling, which for 1-bit data is a logical OR. It writes the pooled rows into a second SRAM. The block is started by a one-cycle run pulse, handles one feature map per run, and reports busy/done back to the top-level controller.

## Interface
- No parameters; address width 12 and data width 16 match the rest of the design.
- clk  input  1  single system clock, all state on rising edge
- reset_b  input  1  asynchronous, active-low reset
- pool_run  input  1  start request, sampled only in IDLE
- pool_dim  input  2  input-image dimension code, same encoding as the convolution engine:
  - 2'b1x: 16, giving map size M=14
  - 2'b01: 12, giving M=10
  - 2'b00: 10, giving M=8
- pool_busy  output  1  high while a map is being processed
- pool_done  output  1  one-cycle pulse at completion
- pool_sram_read_address  output  12  feature-map SRAM read address
- sram_pool_read_data  input  16  read data, valid one cycle after the address is presented
- pool_sram_write_address  output  12  pooled-map SRAM write address
- pool_sram_write_data  output  16  pooled row
- pool_sram_write_enable  output  1  write strobe, one word per cycle when high

## Operation
- States:
  - IDLE → READ on pool_run=1.
  - READ → DRAIN after address M-1 has been issued.
  - DRAIN → IDLE after the last write; pool_done pulses on this transition.
- pool_dim is latched on the IDLE→READ edge and ignored afterwards.
- The feature map occupies read addresses 0..M-1. Row r holds bit c at position c, for c<M. Bits M..15 of every read word are ignored.
- Pairs are row (2k, 2k+1), for k = 0..M/2-1.
- Output bit j of pooled row k = r[2k][2j] | r[2k][2j+1] | r[2k+1][2j] | r[2k+1][2j+1], for j < M/2.
- Output bits M/2..15 are 0.
- Pooled row k is written to address k, so addresses 0..M/2-1 are used: 7, 5 or 4 words.
- The even row is captured in a holding register. The odd row is combined with it on arrival, and the result is registered into pool_sram_write_data.
- pool_run while busy is ignored, with no restart and no queueing.
- In IDLE:
  - read address = 0, write address = 0, write enable = 0.
  - pool_sram_write_data holds its last value.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset asserted mid-run aborts immediately, with no further writes.
- Let t0 be the edge at which pool_run=1 is sampled in IDLE.
- t0+1:
  - pool_busy=1.
  - Read address = 0, incrementing by 1 each cycle through M-1, which is reached at t0+M.
- Data for address a is valid during cycle t0+2+a.
- Write of pooled row k: pool_sram_write_enable=1 during cycle t0+4+2k.
  - Address k and data are stable that same cycle.
  - Enable is 0 in the cycles between writes.
- Last write (k=M/2-1) is at t0+M+2.
- t0+M+3:
  - pool_busy=0 and pool_done=1, both for exactly one cycle of done.
  - State is IDLE.
- A new pool_run is accepted at the t0+M+3 edge (sampled while in IDLE), so back-to-back runs are possible with one idle cycle.
- Total busy cycles = M+2.

## Test plan
- **M=8 (pool_dim=00), all rows 16'h00FF:** 4 writes at addresses 0..3, data 16'h000F each. Busy lasts 10 cycles, then a single done pulse.
- **M=14 (pool_dim=10), even rows 16'h5555, odd rows 16'hAAAA:** 7 writes, addresses 0..6, data 16'h007F each. Enables occur on alternate cycles, starting at t0+4.
- **M=10 (pool_dim=01), all rows zero except row 3 = 16'h0200:** writes at addresses 0..4; address 1 = 16'h0010, all others 16'h0000. Repeat with rows 16'hFC00: every output is 16'h0000, since the out-of-range bits are ignored.
- **pool_run re-pulsed at t0+3 and pool_dim changed mid-run (M=8 start):** the run is unaffected and still produces 4 writes; pool_run asserted at the t0+11 edge starts a second run with busy=1 at t0+12.
- **reset_b pulled low at t0+5 of an M=14 run:** all outputs are 0 immediately (asynchronous), no writes follow, and a subsequent run executes normally from address 0.
